// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI memory slave: FSM states, channel field widths, burst context.
package axi_mem_pkg;
  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_LEN_WIDTH  = 4;
  localparam int unsigned CTX_ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_DATA,
    WR_RESP
  } state_t;

  // addr always points at the next word to read or write; only its low DEPTH_LOG2 bits index the array
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [CTX_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [AXI_LEN_WIDTH-1:0]  beat;
  } burst_ctx_t;
endpackage

// File: rtl/axi_mem_slave_if.sv
// Five-channel AXI-style bus (AW/W/B/AR/R) between the core and the memory slave.
interface axi_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32
);
  import axi_mem_pkg::*;

  logic                     AWVALID, AWREADY;
  logic [AXI_ID_WIDTH-1:0]  AWID;
  logic [AXI_LEN_WIDTH-1:0] AWLEN;
  logic [ADDR_WIDTH-1:0]    AWADDR;

  logic                     WVALID, WREADY, WLAST;
  logic [AXI_ID_WIDTH-1:0]  WID;
  logic [DATA_WIDTH-1:0]    WDATA;

  logic                     BVALID, BREADY;
  logic [AXI_ID_WIDTH-1:0]  BID;

  logic                     ARVALID, ARREADY;
  logic [AXI_ID_WIDTH-1:0]  ARID;
  logic [AXI_LEN_WIDTH-1:0] ARLEN;
  logic [ADDR_WIDTH-1:0]    ARADDR;

  logic                     RVALID, RREADY, RLAST;
  logic [AXI_ID_WIDTH-1:0]  RID;
  logic [DATA_WIDTH-1:0]    RDATA;

  modport master (
    output AWVALID, AWID, AWLEN, AWADDR, input AWREADY,
    output WVALID, WLAST, WID, WDATA, input WREADY,
    input  BVALID, BID, output BREADY,
    output ARVALID, ARID, ARLEN, ARADDR, input ARREADY,
    input  RVALID, RLAST, RID, RDATA, output RREADY
  );

  modport slave (
    input  AWVALID, AWID, AWLEN, AWADDR, output AWREADY,
    input  WVALID, WLAST, WID, WDATA, output WREADY,
    output BVALID, BID, input BREADY,
    input  ARVALID, ARID, ARLEN, ARADDR, output ARREADY,
    output RVALID, RLAST, RID, RDATA, input RREADY
  );
endinterface

// File: rtl/axi_mem_array.sv
// Word array with one synchronous write port and a combinational read port.
module axi_mem_array #(
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_mem_slave.sv
// AXI-style burst memory slave, one transaction at a time, configurable first-beat read latency.
// Define AXI_MEM_STATS_EN to build the burst/stall statistics counters; otherwise they read 0.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LOG2   = 16,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_mem_slave_if.slave       bus,
  output logic [31:0]          stat_rd_bursts,
  output logic [31:0]          stat_wr_bursts,
  output logic [31:0]          stat_stall_cycles
);
  state_t                  state;
  burst_ctx_t              ctx;
  logic                    grant_rd;
  logic                    awready_q, arready_q, wready_q, bvalid_q, rvalid_q, rlast_q;
  logic [AXI_ID_WIDTH-1:0] bid_q, rid_q;
  logic [DATA_WIDTH-1:0]   rdata_q, mem_rdata;
  logic [3:0]              lat_cnt;
  logic                    ar_rdy, aw_rdy, ar_hs, aw_hs, w_hs, r_hs, b_hs, first_beat;
  logic [DEPTH_LOG2-1:0]   mem_addr;

  // Loser of a simultaneous AR/AW request sees its READY masked in the same cycle
  assign ar_rdy = arready_q && !(bus.AWVALID && !grant_rd);
  assign aw_rdy = awready_q && !(bus.ARVALID && grant_rd);

  assign ar_hs = bus.ARVALID && ar_rdy;
  assign aw_hs = bus.AWVALID && aw_rdy;
  assign w_hs  = bus.WVALID && wready_q;
  assign r_hs  = rvalid_q && bus.RREADY;
  assign b_hs  = bvalid_q && bus.BREADY;

  assign first_beat = (state == RD_WAIT && lat_cnt == '0) || (state == RD_BURST && !rvalid_q);
  assign mem_addr   = DEPTH_LOG2'(ctx.addr);

  axi_mem_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk   (clk),
    .we    (w_hs),
    .waddr (mem_addr),
    .wdata (bus.WDATA),
    .raddr (mem_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_rd  <= 1'b1;
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      bid_q     <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      ctx       <= '0;
      lat_cnt   <= '0;
    end else begin
      if (first_beat) begin
        rdata_q  <= mem_rdata;
        rvalid_q <= 1'b1;
        rid_q    <= ctx.id;
        rlast_q  <= (ctx.len == '0);
        ctx.addr <= ctx.addr + 1'b1;
      end
      unique case (state)
        IDLE: begin
          arready_q <= 1'b1;
          awready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            grant_rd  <= !grant_rd;
            ctx       <= '{id: bus.ARID, addr: CTX_ADDR_WIDTH'(bus.ARADDR), len: bus.ARLEN, beat: '0};
            lat_cnt   <= 4'(READ_LATENCY - 1);
            state     <= (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
          end else if (aw_hs) begin
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            grant_rd  <= !grant_rd;
            ctx       <= '{id: bus.AWID, addr: CTX_ADDR_WIDTH'(bus.AWADDR), len: bus.AWLEN, beat: '0};
            wready_q  <= 1'b1;
            state     <= WR_DATA;
          end
        end
        RD_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
          else               state   <= RD_BURST;
        end
        RD_BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              awready_q <= 1'b1;
              state     <= IDLE;
            end else begin
              rdata_q  <= mem_rdata;
              ctx.addr <= ctx.addr + 1'b1;
              ctx.beat <= ctx.beat + 1'b1;
              rlast_q  <= (ctx.beat + 1'b1 == ctx.len);
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            ctx.addr <= ctx.addr + 1'b1;
            ctx.beat <= ctx.beat + 1'b1;
            if (ctx.beat == ctx.len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= ctx.id;
              state    <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            awready_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ARREADY = ar_rdy;
  assign bus.AWREADY = aw_rdy;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RID     = rid_q;
  assign bus.RDATA   = rdata_q;

  // Write bursts end by beat count; WLAST is only cross-checked
  wlast_matches_count: assert property (@(posedge clk) disable iff (rst)
    w_hs |-> (bus.WLAST == (ctx.beat == ctx.len)));

`ifdef AXI_MEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (ar_hs && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (b_hs && wr_cnt != '1)  wr_cnt <= wr_cnt + 1'b1;
      if (((rvalid_q && !bus.RREADY) || (bvalid_q && !bus.BREADY)) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stat_rd_bursts    = rd_cnt;
  assign stat_wr_bursts    = wr_cnt;
  assign stat_stall_cycles = stall_cnt;
`else
  assign stat_rd_bursts    = '0;
  assign stat_wr_bursts    = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected R/B responses, a negedge monitor checks them.
module tb_axi_mem_slave;
  logic clk, rst;
  logic [31:0] stat_rd, stat_wr, stat_stall;

  axi_mem_slave_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

  axi_mem_slave #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .DEPTH_LOG2(16), .READ_LATENCY(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .stat_rd_bursts    (stat_rd),
    .stat_wr_bursts    (stat_wr),
    .stat_stall_cycles (stat_stall)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } r_exp_t;

  r_exp_t      rq[$];
  logic [3:0]  bq[$];
  bit   [31:0] model[bit [15:0]];
  int checks = 0, failures = 0, r_seen = 0, b_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // which: 0 = ARREADY, 1 = AWREADY, 2 = either
  task automatic wait_ready(input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? bus.ARREADY : (which == 1) ? bus.AWREADY : (bus.ARREADY || bus.AWREADY);
    end
    if (!seen) timeout(name);
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len);
    for (int k = 0; k <= int'(len); k++)
      rq.push_back('{data: model[16'(addr + 26'(k))], id: id, last: (k == int'(len))});
    bus.ARVALID = 1'b1; bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.RREADY = 1'b0;
    wait_ready(0, "ar_ready_wait");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len);
    bq.push_back(id);
    bus.AWVALID = 1'b1; bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    wait_ready(1, "aw_ready_wait");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [25:0] addr, input logic [3:0] len, input logic [31:0] base);
    for (int k = 0; k <= int'(len); k++) begin
      bus.WVALID = 1'b1; bus.WDATA = base + 32'(k); bus.WLAST = (k == int'(len)); bus.WID = 4'h0;
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = bus.WREADY;
        end
        if (!seen) timeout("w_ready_wait");
      end
      @(posedge clk); #1;
      model[16'(addr + 26'(k))] = base + 32'(k);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  // Cycle c counts posedges after the AR handshake edge; pattern mode drives RREADY 1,0,0,1,0,0...
  task automatic run_read(input int nbeats, input bit pattern, output int first_c);
    int target = r_seen + nbeats;
    first_c = -1;
    for (int c = 1; c < 200 && r_seen < target; c++) begin
      @(posedge clk); #1;
      bus.RREADY = pattern ? (c % 3 == 1) : 1'b1;
      @(negedge clk); #1;
      if (first_c < 0 && bus.RVALID) first_c = c;
    end
    if (r_seen < target) timeout("r_beats_wait");
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
  endtask

  task automatic run_b(input int delay);
    int target = b_seen + 1;
    bus.BREADY = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk); #1;
      chk("b_stall_bvalid", bus.BVALID, 1);
      chk("b_stall_awready", bus.AWREADY, 0);
      @(posedge clk); #1;
    end
    bus.BREADY = 1'b1;
    for (int i = 0; i < 50 && b_seen < target; i++) begin
      @(negedge clk); #1;
    end
    if (b_seen < target) timeout("b_resp_wait");
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input int rd, input int wr, input int st);
`ifdef AXI_MEM_STATS_EN
    chk({tag, "_stat_rd"}, stat_rd, 64'(rd));
    chk({tag, "_stat_wr"}, stat_wr, 64'(wr));
    chk({tag, "_stat_stall"}, stat_stall, 64'(st));
`else
    chk({tag, "_stat_rd"}, stat_rd, 0);
    chk({tag, "_stat_wr"}, stat_wr, 0);
    chk({tag, "_stat_stall"}, stat_stall, 0);
    if (rd + wr + st < 0) $display("unreachable");
`endif
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold-stability during stalls
  initial begin
    logic pr_stall = 1'b0, pb_stall = 1'b0, p_rst = 1'b1, p_rlast = 1'b0;
    logic [31:0] p_rdata = '0;
    logic [3:0]  p_rid = '0, p_bid = '0;
    r_exp_t e;
    logic [3:0] eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.RVALID && bus.RREADY) begin
          if (rq.size() == 0) timeout("r_unexpected_beat");
          else begin
            e = rq.pop_front();
            chk("r_data", bus.RDATA, e.data);
            chk("r_id", bus.RID, e.id);
            chk("r_last", bus.RLAST, e.last);
          end
          r_seen++;
        end
        if (bus.BVALID && bus.BREADY) begin
          if (bq.size() == 0) timeout("b_unexpected_resp");
          else begin
            eb = bq.pop_front();
            chk("b_id", bus.BID, eb);
          end
          b_seen++;
        end
        if (pr_stall && !p_rst) begin
          chk("r_hold_valid", bus.RVALID, 1);
          chk("r_hold_data", bus.RDATA, p_rdata);
          chk("r_hold_id", bus.RID, p_rid);
          chk("r_hold_last", bus.RLAST, p_rlast);
        end
        if (pb_stall && !p_rst) begin
          chk("b_hold_valid", bus.BVALID, 1);
          chk("b_hold_id", bus.BID, p_bid);
        end
        if (bus.ARVALID && bus.AWVALID) chk("one_ready", bus.ARREADY && bus.AWREADY, 0);
      end
      pr_stall = bus.RVALID && !bus.RREADY;
      pb_stall = bus.BVALID && !bus.BREADY;
      p_rdata = bus.RDATA; p_rid = bus.RID; p_rlast = bus.RLAST; p_bid = bus.BID;
      p_rst = rst;
    end
  end

  initial begin
    int fc;
    rst = 1'b1;
    bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWLEN = '0; bus.AWADDR = '0;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.WID = '0; bus.WDATA = '0;
    bus.BREADY = 1'b0;
    bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARLEN = '0; bus.ARADDR = '0;
    bus.RREADY = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_awready", bus.AWREADY, 0);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_rlast", bus.RLAST, 0);
    chk("rst_bid", bus.BID, 0);
    chk("rst_rid", bus.RID, 0);
    chk("rst_rdata", bus.RDATA, 0);
    chk_stats("rst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write then read-back with first-beat latency
    do_aw(4'h2, 26'h100, 4'd3);
    do_w(26'h100, 4'd3, 32'hA0);
    run_b(0);
    do_ar(4'h5, 26'h100, 4'd3);
    run_read(4, 1'b0, fc);
    chk("rd_latency", 64'(fc), 4);

    // Long burst with RREADY stalls
    do_aw(4'h3, 26'h200, 4'd7);
    do_w(26'h200, 4'd7, 32'h1000);
    run_b(0);
    do_ar(4'h9, 26'h200, 4'd7);
    run_read(8, 1'b1, fc);
    chk_stats("stall", 2, 2, 14);

    // Address wrap at the top of the array, and upper address bits ignored
    do_aw(4'h4, 26'hFFFF, 4'd1);
    do_w(26'hFFFF, 4'd1, 32'hBEEF0);
    run_b(0);
    do_ar(4'h6, 26'hFFFF, 4'd1);
    run_read(2, 1'b0, fc);
    do_ar(4'h1, 26'h1AFFFF, 4'd1);
    run_read(2, 1'b0, fc);

    // B backpressure for 10 cycles
    do_aw(4'hC, 26'h300, 4'd0);
    do_w(26'h300, 4'd0, 32'h55AA);
    run_b(10);
    chk_stats("bstall", 4, 4, 24);

    // Fresh reset: grant pointer favours read first, then write
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_stats("rst2", 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;

    bus.ARVALID = 1'b1; bus.ARID = 4'hA; bus.ARADDR = 26'h100; bus.ARLEN = 4'd0;
    bus.AWVALID = 1'b1; bus.AWID = 4'hB; bus.AWADDR = 26'h400; bus.AWLEN = 4'd0;
    rq.push_back('{data: 32'hA0, id: 4'hA, last: 1'b1});
    wait_ready(2, "grant1_wait");
    chk("grant1_arready", bus.ARREADY, 1);
    chk("grant1_awready", bus.AWREADY, 0);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    run_read(1, 1'b0, fc);

    bus.ARVALID = 1'b1; bus.ARID = 4'hD; bus.AWVALID = 1'b1;
    wait_ready(2, "grant2_wait");
    chk("grant2_awready", bus.AWREADY, 1);
    chk("grant2_arready", bus.ARREADY, 0);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    bq.push_back(4'hB);
    do_w(26'h400, 4'd0, 32'h77);
    run_b(0);

    // Reset while beat 2 of a 4-beat read is on the bus
    do_ar(4'h7, 26'h100, 4'd3);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      bus.RREADY = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.RREADY = 1'b0;
    @(negedge clk);
    chk("rst_mid_beat2_present", bus.RVALID, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", bus.RVALID, 0);
    chk("rst_mid_rlast", bus.RLAST, 0);
    chk("rst_mid_arready", bus.ARREADY, 0);
    rq.delete();
    do_ar(4'h8, 26'h200, 4'd1);
    run_read(2, 1'b0, fc);
    chk("rst_mid_new_latency", 64'(fc), 4);

    chk("r_queue_empty", 64'(rq.size()), 0);
    chk("b_queue_empty", 64'(bq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI-style memory slave that sits directly downstream of the core's five AXI channels (AW/W/B/AR/R) and serves the memory arbiter's burst requests.
- Models main memory as a word array with configurable first-beat read latency and services one transaction at a time.
- Serves as the bench-side memory for the core and as the synthesizable stand-in for a board RAM.

Parameters:
- ADDR_WIDTH, 26, word address width; matches core `ADDR_WIDTH.
- DATA_WIDTH, 32, beat width; matches core `DATA_WIDTH.
- DEPTH_LOG2, 16, log2 of words in the array; address bits above it are ignored, so addresses wrap modulo depth.
- READ_LATENCY, 4, cycles from AR handshake to first RVALID; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- AWVALID in 1, AWREADY out 1, AWID in 4, AWLEN in 4, AWADDR in ADDR_WIDTH: write address channel
- WVALID in 1, WREADY out 1, WLAST in 1, WID in 4, WDATA in DATA_WIDTH: write data channel
- BVALID out 1, BREADY in 1, BID out 4: write response channel
- ARVALID in 1, ARREADY out 1, ARID in 4, ARLEN in 4, ARADDR in ADDR_WIDTH: read address channel
- RVALID out 1, RREADY in 1, RLAST out 1, RID out 4, RDATA out DATA_WIDTH: read data channel
- stat_rd_bursts out 32, stat_wr_bursts out 32, stat_stall_cycles out 32: statistics counters (see Optional Feature)

Behaviour:
- Reset values: AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST = 0; BID, RID, RDATA = 0; FSM = IDLE; grant pointer = read. Array contents are not reset.
- Burst length is LEN+1 beats (1..16). Burst type is INCR on word addresses: beat k uses address (ADDR+k) mod 2^DEPTH_LOG2.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP.
- IDLE:
  - AWREADY and ARREADY are both driven 1 only in IDLE, as registered outputs.
  - Only one handshake is taken per cycle.
  - If ARVALID and AWVALID are both high, the grant pointer chooses the winner. Reset favours read; the pointer flips after every granted transaction. The loser's READY is deasserted combinationally that cycle.
  - AR handshake: capture ARID, ARADDR, ARLEN; load latency counter with READ_LATENCY-1; go to RD_WAIT (or straight to RD_BURST if READ_LATENCY=1).
  - AW handshake: capture AWID, AWADDR, AWLEN; go to WR_DATA.
- RD_WAIT: count down; at 0, drive RDATA = mem[addr], RVALID=1, RID = captured ID, RLAST = (LEN==0); go to RD_BURST.
- RD_BURST:
  - On RVALID&&RREADY: if last beat, drop RVALID and RLAST and return to IDLE. Otherwise load RDATA with the next word in the same cycle (back-to-back beats, no bubble) and set RLAST on the final beat.
  - While RREADY=0, RDATA, RID, RLAST and RVALID are held stable.
  - Array read is combinational; RDATA is registered.
- WR_DATA:
  - WREADY=1 throughout.
  - Each WVALID&&WREADY writes WDATA to the current address and increments the beat counter.
  - After beat LEN+1, drop WREADY and go to WR_RESP.
  - Termination is by count only. A WLAST mismatch (early or late) is flagged by a simulation assertion and does not change behaviour.
  - WID is ignored.
- WR_RESP: BVALID=1, BID = captured AWID; on BREADY, drop BVALID and return to IDLE.
- First-beat read latency is READ_LATENCY cycles after the AR handshake edge. A write is visible to any read accepted afterwards.
- Reset mid-burst: the FSM returns to IDLE on the next edge. All VALID/READY outputs go to 0 and the partial burst is abandoned. Words already written remain in the array.
- Counter wrap: beat counter is 4 bits; address arithmetic is modulo array depth (reading at 0xFFFF with LEN=1 returns mem[0xFFFF], then mem[0]).

Optional Feature:
- AXI_MEM_STATS_EN defined:
  - stat_rd_bursts increments on each AR handshake.
  - stat_wr_bursts increments on each B handshake.
  - stat_stall_cycles increments each cycle RVALID&&!RREADY or BVALID&&!BREADY.
  - All three saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: the three ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package axi_mem_pkg holds: state enum (IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP), AXI_ID_WIDTH=4, AXI_LEN_WIDTH=4, and a burst_ctx_t struct {id, addr, len, beat}.
- One sub-module: axi_mem_array, a word array with one write port and combinational read, DEPTH_LOG2-parameterised.

Test Plan:
- Write AWADDR=0x100, AWLEN=3, data 0xA0..0xA3, then read ARADDR=0x100, ARLEN=3 -> RDATA 0xA0,0xA1,0xA2,0xA3; RLAST only on beat 4; RID equals ARID=5; first RVALID exactly 4 cycles after the AR edge.
- Read LEN=7 with RREADY toggling 1,0,0,1... -> RDATA, RID, RLAST held during low cycles; 8 beats in order; stat_stall_cycles counts the low cycles (STATS_EN build).
- ARVALID and AWVALID raised in the same cycle twice after reset -> first grant is read, second is write; only one READY per cycle.
- Write AWADDR=0xFFFF, AWLEN=1 -> words land at 0xFFFF and 0x0000; read back matches.
- Assert rst in the middle of beat 2 of a LEN=3 read -> RVALID=0 next cycle, FSM IDLE; new AR is accepted and served correctly.
- BREADY held 0 for 10 cycles -> BVALID and BID stable; AWREADY stays 0 until the B handshake completes.
